// File: rtl/uart_mem_server_if.sv
// Request/response byte channel between the UART pair and the memory server.
// slave = server side; master = UART/harness side.
interface uart_mem_server_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       rx_drop;

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, busy, rx_drop
  );

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, busy, rx_drop
  );
endinterface

// File: rtl/uart_mem_server.sv
// UART memory-protocol responder: parses opcode/address/data bytes and serves byte reads/writes from a RAM.
// First response byte is valid one cycle after the consuming edge; tx_valid/tx_data hold while tx_ready is low.
module uart_mem_server #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  uart_mem_server_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_WACK, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [2:0]      len_q, len_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      acnt_q, acnt_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rx_drop_q, rx_drop_d;

  logic [7:0]      mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   idx_cur;
  logic            tx_fire;

  assign idx_cur = addr_q + AW'(cnt_q);
  assign tx_fire = tx_valid_q & bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    len_d      = len_q;
    addr_d     = addr_q;
    acnt_d     = acnt_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rx_drop_d  = rx_drop_q;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[6:3] == 4'd0) begin
            wr_d    = bus.rx_data[7];
            len_d   = bus.rx_data[2:0];
            acnt_d  = 2'd0;
            cnt_d   = 3'd0;
            state_d = S_ADDR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'hEE;
            state_d    = S_ERR;
          end
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          // Only address bits below AW are kept; the rest of the 32-bit field is ignored.
          for (int j = 0; j < AW; j++) begin
            if (j / 8 == int'(acnt_q)) addr_d[j] = bus.rx_data[j % 8];
          end
          acnt_d = acnt_q + 2'd1;
          if (acnt_q == 2'd3) begin
            if (wr_q) begin
              state_d = S_WDATA;
            end else begin
              state_d    = S_RDATA;
              tx_valid_d = 1'b1;
              tx_data_d  = mem[addr_d];
            end
          end
        end
      end
      S_WDATA: begin
        if (bus.rx_valid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == len_q) begin
            cnt_d      = 3'd0;
            state_d    = S_WACK;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'hAC;
          end
        end
      end
      S_RDATA: begin
        if (bus.rx_valid) rx_drop_d = 1'b1;
        if (tx_fire) begin
          if (cnt_q == len_q) begin
            cnt_d      = 3'd0;
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            cnt_d     = cnt_q + 3'd1;
            tx_data_d = mem[idx_cur + AW'(1)];
          end
        end
      end
      S_WACK, S_ERR: begin
        if (bus.rx_valid) rx_drop_d = 1'b1;
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      len_q      <= 3'd0;
      addr_q     <= '0;
      acnt_q     <= 2'd0;
      cnt_q      <= 3'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      acnt_q     <= acnt_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_cur] <= bus.rx_data;
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_uart_mem_server.sv
// Bench for uart_mem_server: scenario tasks against a byte-array memory model with exact response timing.
module tb_uart_mem_server;

  localparam int DEPTH = 4096;

  logic clk;
  logic rst;
  uart_mem_server_if bus ();

  uart_mem_server #(.DEPTH(DEPTH), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];
  bit         ref_vld [DEPTH];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [63:0] d, input string nm);
    logic [2:0] l;
    int idx;
    l = 3'(len - 1);
    send_byte({1'b1, 4'b0000, l});
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    for (int i = 0; i < len; i++) begin
      send_byte(d[8*i +: 8]);
      idx = (int'(a % DEPTH) + i) % DEPTH;
      ref_mem[idx] = d[8*i +: 8];
      ref_vld[idx] = 1'b1;
    end
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hAC) begin
      errors++;
      $display("FAIL %s wack: tx_valid=%b tx_data=%h, required 1/ac", nm, bus.tx_valid, bus.tx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s wack_end: tx_valid=%b busy=%b, required 0/0", nm, bus.tx_valid, bus.busy);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input int stall_at, input int stall_n,
                         input int drop_at, input string nm);
    logic [2:0] l;
    logic [7:0] held;
    int idx;
    l = 3'(len - 1);
    send_byte({1'b0, 4'b0000, l});
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    for (int i = 0; i < len; i++) begin
      idx = (int'(a % DEPTH) + i) % DEPTH;
      if (i == stall_at) begin
        bus.tx_ready = 1'b0;
        held = bus.tx_data;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          checks++;
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
            errors++;
            $display("FAIL %s stall%0d: tx_valid=%b tx_data=%h, required 1/%h", nm, s, bus.tx_valid, bus.tx_data, held);
          end
        end
        bus.tx_ready = 1'b1;
      end
      if (i == drop_at) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
      end
      checks++;
      if (bus.tx_valid !== 1'b1 || (ref_vld[idx] && bus.tx_data !== ref_mem[idx])) begin
        errors++;
        $display("FAIL %s byte%0d: tx_valid=%b tx_data=%h, required 1/%h", nm, i, bus.tx_valid, bus.tx_data, ref_mem[idx]);
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_end: tx_valid=%b busy=%b, required 0/0", nm, bus.tx_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.busy !== 1'b0 || bus.rx_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx_valid=%b tx_data=%h busy=%b rx_drop=%b, required 0/00/0/0",
               bus.tx_valid, bus.tx_data, bus.busy, bus.rx_drop);
    end
  endtask

  task automatic test_write_read();
    do_write(32'h0000_0010, 2, 64'h2211, "wr_basic");
    do_read(32'h0000_0010, 2, -1, 0, -1, "rd_basic");
  endtask

  task automatic test_wrap();
    do_write(32'h0000_0FFE, 4, 64'h0403_0201, "wr_wrap");
    do_read(32'h0000_0000, 2, -1, 0, -1, "rd_wrap");
    do_read(32'h0000_0FFE, 4, -1, 0, -1, "rd_wrap_full");
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    d = {$urandom, $urandom};
    do_write(32'h0000_0100, 8, d, "wr_bp");
    do_read(32'h0000_0100, 8, 1, 5, -1, "rd_bp");
    do_read(32'h0000_0100, 3, 0, 3, -1, "rd_bp_first");
  endtask

  task automatic test_invalid();
    logic [7:0] op;
    for (int n = 0; n < 5; n++) begin
      op = (n == 0) ? 8'h48 : 8'($urandom);
      if (op[6:3] == 4'd0) op[4] = 1'b1;
      send_byte(op);
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEE) begin
        errors++;
        $display("FAIL invalid_%h: tx_valid=%b tx_data=%h, required 1/ee", op, bus.tx_valid, bus.tx_data);
      end
      @(negedge clk);
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid_end_%h: tx_valid=%b busy=%b, required 0/0", op, bus.tx_valid, bus.busy);
      end
    end
    do_read(32'h0000_0011, 1, -1, 0, -1, "rd_after_inv");
  endtask

  task automatic test_rx_drop();
    checks++;
    if (bus.rx_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pre: rx_drop=%b, required 0", bus.rx_drop);
    end
    do_read(32'h0000_0100, 4, -1, 0, 1, "rd_drop");
    checks++;
    if (bus.rx_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_flag: rx_drop=%b, required 1", bus.rx_drop);
    end
    do_read(32'h0000_0010, 2, -1, 0, -1, "rd_after_drop");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [63:0] d;
    int len;
    for (int n = 0; n < 20; n++) begin
      a   = $urandom;
      len = int'($urandom_range(1, 8));
      d   = {$urandom, $urandom};
      do_write(a, len, d, "wr_rand");
      do_read(a, int'($urandom_range(1, len)), -1, 0, -1, "rd_rand");
      a = {$urandom, 12'h000} | 32'(int'(a % DEPTH) + int'($urandom_range(0, 3)));
      do_read(a, int'($urandom_range(1, 8)), int'($urandom_range(0, 7)), 2, -1, "rd_rand_alias");
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b, required 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.rx_drop !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b tx_valid=%b rx_drop=%b, required 0/0/0", bus.busy, bus.tx_valid, bus.rx_drop);
    end
    @(negedge clk);
    rst = 1'b0;
    do_write(32'h0000_0000, 1, 64'hAB, "wr_after_rst");
    do_read(32'h0000_0000, 1, -1, 0, -1, "rd_after_rst");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_invalid();
    test_rx_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
